gate_pipe: RTL and testbench
============================

# gate_pipe

Parametrised, pipelined bitwise logic unit. It generalises the single-bit inverter to a WIDTH-bit datapath with eight selectable gate operations, a configurable register pipeline and a valid/ready handshake on both sides. It is the team's general gate primitive for datapaths that need registered, flow-controlled logic operations with zero and parity status.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1..64.
- STAGES, 2: pipeline register stages (latency); legal range 1..4. Any other value is an elaboration error.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input transaction present.
- in_ready  output  1  unit accepts input this cycle.
- op  input  3  operation select, sampled with the operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT and BUF.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- y  output  WIDTH  result.
- zero  output  1  high when y == 0.
- parity  output  1  XOR reduction of y.

## Operation
- Op codes:
  - 0 NOT (~a)
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 NAND
  - 5 NOR
  - 6 XNOR
  - 7 BUF (a)
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Computation: result, zero and parity are computed combinationally from the accepted a/b/op and captured into stage 1. Later stages carry {result, zero, parity} unchanged.
- Stage register: each stage holds one valid bit plus its payload.
- Stage advance rule: stage i loads from stage i-1 when ready_i = !valid_i || ready_(i+1). ready_(STAGES+1) = out_ready.
- in_ready is ready_1. It is combinational from out_ready and the valid bits; there is no register on this path.
- Outputs: out_valid, y, zero and parity come from the last stage.
- Bubbles: bubbles collapse. An empty stage accepts data even while downstream is stalled.
- Op binding: op is bound per transaction. Changing op never affects transactions already in flight.
- Order: strict FIFO order; no reordering, duplication or loss.

## Timing
- Reset values (asynchronous, while rst_n is low): all valid bits 0, out_valid 0, y 0, zero 0, parity 0. in_ready reads 1 from the first edge after release.
- Latency: with out_ready held high, a transaction accepted at edge N appears at the outputs after edge N+STAGES-1. out_valid is high in cycle N+STAGES. Throughput is one transaction per cycle.
- Stall: while out_valid && !out_ready, y, zero and parity hold stable.
- Full pipeline: the pipeline holds exactly STAGES transactions. When all stages are valid and out_ready is low, in_ready is low.
- Full with simultaneous pop: when all stages are valid and out_ready is high, a new input is accepted in the same cycle and the whole pipe shifts.
- Idle: when in_valid is low, a bubble enters stage 1 and no stage payload is required to change.
- Reset mid-operation: all in-flight transactions are discarded, and out_valid falls immediately (asynchronous). No stale result appears after release.
- Control inputs: in_valid and out_ready must be known (not X) outside reset. Payload is don't-care when in_valid is low.

## Structure
- Package gate_pkg:
  - op code constants / enum (OP_NOT..OP_BUF).
  - localparam bounds for WIDTH and STAGES.
  - a function gate_eval(op, a, b) shared with the bench model.
- Sub-module gate_stage: one valid/payload register with the ready_i rule and the asynchronous active-low reset. Instantiated STAGES times by a generate loop in gate_pipe.
- Top level: the top holds only the gate_eval datapath, the flag computation and the stage chaining.

## Test plan
- Reset: hold rst_n low 3 cycles with in_valid=1 → out_valid=0, y=8'h00. After release, in_ready=1 and no output appears without input.
- NOT (WIDTH=8, STAGES=2): op=0, a=8'hA5 → y=8'h5A with zero=0, parity=0; out_valid rises exactly 2 cycles after acceptance.
- Back-to-back stream, out_ready=1, one transaction per cycle:
  - AND F0/3C → 8'h30, parity=0
  - XOR FF/FF → 8'h00, zero=1
  - NOR 00/00 → 8'hFF, parity=0
  - BUF 8'h01 → 8'h01, parity=1
  - Required: results appear in order on consecutive cycles.
- Backpressure: out_ready=0, offer 3 transactions → exactly 2 accepted, in_ready=0, y held stable. Raise out_ready → the third input is accepted in the same cycle and all results drain in order.
- Reset mid-stream: 2 transactions in flight, pulse rst_n low between edges → out_valid drops without a clock edge. After release, neither result is ever emitted.
- Degenerate configuration (WIDTH=1, STAGES=1): op=0, a=1 → y=0, zero=1, parity=0, out_valid one cycle after acceptance. Then a=0 → y=1.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared op codes, parameter bounds and the gate evaluation function.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Evaluated at the maximum width; callers keep the low WIDTH bits.
  function automatic logic [WIDTH_MAX-1:0] gate_eval(
    input logic [2:0]           op,
    input logic [WIDTH_MAX-1:0] a,
    input logic [WIDTH_MAX-1:0] b
  );
    logic [WIDTH_MAX-1:0] r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      default: r = a;  // OP_BUF
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_stage.sv
// gate_stage: one valid bit plus payload register of the gate pipeline.
// Latency: 1 cycle. Ports: clk/rst_n; up_vld_i/up_dat_i from upstream;
// dn_rdy_i from downstream; rdy_o (this stage can load); vld_o/dat_o to downstream.
// Backpressure: loads whenever empty or downstream ready, so bubbles collapse.
module gate_stage #(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_vld_i,
  input  logic [PW-1:0] up_dat_i,
  input  logic          dn_rdy_i,
  output logic          rdy_o,
  output logic          vld_o,
  output logic [PW-1:0] dat_o
);

  logic          vld_q, vld_d;
  logic [PW-1:0] dat_q, dat_d;

  assign rdy_o = !vld_q || dn_rdy_i;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (rdy_o) begin
      vld_d = up_vld_i;
      // Payload only moves with a real transaction; bubbles leave it untouched.
      if (up_vld_i) begin
        dat_d = up_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/gate_pipe.sv
// gate_pipe: WIDTH-bit registered gate unit (NOT/AND/OR/XOR/NAND/NOR/XNOR/BUF)
// with zero/parity flags. Latency STAGES cycles, one transaction per cycle.
// Backpressure: valid/ready both sides; in_ready is combinational from out_ready.
// Ports: clk, rst_n (async low); in_valid/in_ready/op/a/b input side;
// out_valid/out_ready/y/zero/parity output side (driven from the last stage).
module gate_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  // Payload layout: {result, zero, parity}.
  localparam int PW = WIDTH + 2;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_err
    $error("gate_pipe: WIDTH must be 1..64 and STAGES 1..4");
  end

  logic [WIDTH_MAX-1:0] a_ext, b_ext, eval_full;
  logic [WIDTH-1:0]     res;
  logic [PW-1:0]        head_dat;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
  end

  assign eval_full = gate_eval(op, a_ext, b_ext);
  assign res       = eval_full[WIDTH-1:0];
  assign head_dat  = {res, ~|res, ^res};

  // Upper evaluation bits beyond WIDTH are intentionally discarded.
  logic unused_eval;
  assign unused_eval = ^eval_full;

  // Each stage's forward inputs come from the previous stage and its
  // downstream ready from the next one; the chain closes on out_ready.
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic          vld_in;
    logic [PW-1:0] dat_in;
    logic          dn_rdy;
    logic          rdy;
    logic          vld;
    logic [PW-1:0] dat;

    if (i == 0) begin : g_head
      assign vld_in = in_valid;
      assign dat_in = head_dat;
    end else begin : g_link
      assign vld_in = g_st[i-1].vld;
      assign dat_in = g_st[i-1].dat;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_next
      assign dn_rdy = g_st[i+1].rdy;
    end

    gate_stage #(.PW(PW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_vld_i (vld_in),
      .up_dat_i (dat_in),
      .dn_rdy_i (dn_rdy),
      .rdy_o    (rdy),
      .vld_o    (vld),
      .dat_o    (dat)
    );
  end

  assign in_ready  = g_st[0].rdy;
  assign out_valid = g_st[STAGES-1].vld;
  assign y         = g_st[STAGES-1].dat[PW-1:2];
  assign zero      = g_st[STAGES-1].dat[1];
  assign parity    = g_st[STAGES-1].dat[0];

endmodule

// File: tb/tb_gate_pipe.sv
module tb_gate_pipe;

  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, zero, parity;
  logic [2:0] op;
  logic [7:0] a, b, y;

  logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_zero, d_parity;
  logic [2:0] d_op;
  logic [0:0] d_a, d_b, d_y;

  always #5 clk = ~clk;

  gate_pipe #(.WIDTH(8), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity)
  );

  gate_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .op(d_op), .a(d_a), .b(d_b), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .y(d_y), .zero(d_zero), .parity(d_parity)
  );

  typedef struct {
    logic [7:0] y;
    logic       zero;
    logic       parity;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rnd_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table applied bitwise,
  // indexed by {a_bit, b_bit}.
  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    logic [3:0] tt [8];
    logic [7:0] r;
    logic [3:0] t;
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0110;
    tt[4] = 4'b0111; tt[5] = 4'b0001; tt[6] = 4'b1001; tt[7] = 4'b1100;
    t = tt[o];
    for (int k = 0; k < 8; k++) r[k] = t[{av[k], bv[k]}];
    return r;
  endfunction

  function automatic exp_t mk(input logic [7:0] ey, input int acc, input bit lat);
    exp_t e;
    e.y = ey;
    e.zero = (ey == 8'h00);
    e.parity = ($countones(ey) % 2) == 1;
    e.acc = acc;
    e.lat = lat;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every output transfer; also checks
  // that a stalled output holds still.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_y;
  logic       prev_z, prev_p;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (prev_stall && out_valid) begin
        chk("stall_hold", {y, zero, parity}, {prev_y, prev_z, prev_p});
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got y=%0h expected no output", y);
        end else begin
          e = sbq.pop_front();
          chk("y", y, e.y);
          chk("zero", zero, e.zero);
          chk("parity", parity, e.parity);
          if (e.lat) chk("latency", cyc - e.acc, STAGES - 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y = y; prev_z = zero; prev_p = parity;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Randomised output backpressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Starts at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ey, input bit lat);
    int waited = 0;
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
    end else begin
      sbq.push_back(mk(ey, cyc + 1, lat));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    logic [7:0] yhold;
    logic [2:0] ro;
    logic [7:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'hA5; b = 8'h00; out_ready = 1'b1;
    d_in_valid = 1'b1; d_op = 3'd0; d_a = 1'b1; d_b = 1'b0; d_out_ready = 1'b1;

    // Reset with in_valid asserted.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 8'h00);
    chk("rst_zero", zero, 0);
    chk("rst_parity", parity, 0);
    chk("rst_d_out_valid", d_out_valid, 0);
    in_valid = 1'b0; d_in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    chk("idle_no_output", out_valid, 0);

    // Single NOT with latency check.
    @(posedge clk); #1;
    send(3'd0, 8'hA5, 8'h00, 8'h5A, 1);
    wait_empty();

    // Back-to-back stream.
    @(posedge clk); #1;
    send(3'd1, 8'hF0, 8'h3C, 8'h30, 1);
    send(3'd3, 8'hFF, 8'hFF, 8'h00, 1);
    send(3'd5, 8'h00, 8'h00, 8'hFF, 1);
    send(3'd7, 8'h01, 8'hAA, 8'h01, 1);
    wait_empty();

    // Backpressure: two fill the pipe, the third waits.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd2, 8'h0F, 8'hF0, 8'hFF, 0);
    send(3'd6, 8'h3C, 8'h0F, 8'hCC, 0);
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h0F;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    yhold = y;
    repeat (2) begin
      @(negedge clk);
      chk("full_in_ready_hold", in_ready, 0);
      chk("full_y_hold", y, yhold);
    end
    chk("full_head_y", yhold, 8'hFF);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pop_push_in_ready", in_ready, 1);
    sbq.push_back(mk(8'hF0, cyc + 1, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty();

    // Asynchronous reset with two results in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd3, 8'h12, 8'h34, 8'h26, 0);
    send(3'd1, 8'hFF, 8'h81, 8'h81, 0);
    @(negedge clk);
    chk("inflight_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_drop", out_valid, 0);
    sbq.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_stale_result", out_valid, 0);
    chk("post_midrst_in_ready", in_ready, 1);

    // Randomised traffic with random backpressure.
    @(posedge clk); #1;
    rnd_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      send(ro, ra, rb, model(ro, ra, rb), 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_empty();

    // Degenerate WIDTH=1, STAGES=1 instance.
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_op = 3'd0; d_a = 1'b1;
    @(negedge clk);
    chk("d_in_ready", d_in_ready, 1);
    chk("d_idle_out_valid", d_out_valid, 0);
    @(posedge clk); #1;
    d_a = 1'b0;
    @(negedge clk);
    chk("d_out_valid1", d_out_valid, 1);
    chk("d_y1", d_y, 0);
    chk("d_zero1", d_zero, 1);
    chk("d_parity1", d_parity, 0);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk("d_out_valid2", d_out_valid, 1);
    chk("d_y2", d_y, 1);
    chk("d_zero2", d_zero, 0);
    chk("d_parity2", d_parity, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d_drained", d_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
